// File: rtl/z_result_stage_if.sv
// rtl/z_result_stage_if.sv - ALU capture / bus read-back signal bundle for z_result_stage
//
// Purpose: groups the ALU handshake, the bus read requests and the status outputs
//          of the result-holding stage.
// Modports:
//   master - ALU/bus side: drives alu_valid, alu_result, alu_wide, rd_lo, rd_hi
//   slave  - the stage: drives alu_ready, bus_out, bus_drive, rd_err, busy,
//            flag_zero, flag_neg
// Parameter DATA_W: bus width; the ALU result is 2*DATA_W wide.
interface z_result_stage_if #(
    parameter int DATA_W = 32
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [2*DATA_W-1:0]   alu_result;
    logic                  alu_wide;
    logic                  rd_lo;
    logic                  rd_hi;
    logic [DATA_W-1:0]     bus_out;
    logic                  bus_drive;
    logic                  rd_err;
    logic                  busy;
    logic                  flag_zero;
    logic                  flag_neg;

    modport master (
        output alu_valid, alu_result, alu_wide, rd_lo, rd_hi,
        input  alu_ready, bus_out, bus_drive, rd_err, busy, flag_zero, flag_neg
    );

    modport slave (
        input  alu_valid, alu_result, alu_wide, rd_lo, rd_hi,
        output alu_ready, bus_out, bus_drive, rd_err, busy, flag_zero, flag_neg
    );
endinterface

// File: rtl/z_result_stage.sv
// rtl/z_result_stage.sv - holds one 64-bit ALU result and returns it as two 32-bit bus halves
//
// Purpose: captures an ALU result through a valid/ready handshake, derives zero/negative
//          flags at capture time and hands the low/high halves back onto the internal bus
//          on request; frees itself once the required halves have been read.
// Ports:
//   clk - rising-edge clock
//   clr - asynchronous active-high reset
//   zif - z_result_stage_if.slave (ALU handshake, rd_lo/rd_hi requests, bus_out/bus_drive,
//         rd_err, busy, flag_zero, flag_neg)
// Configuration: define Z_RESULT_FLAGS_EN to build the zero/negative flag logic;
//                without it flag_zero and flag_neg are tied to 0.
module z_result_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    z_result_stage_if.slave   zif
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        LO_DONE = 2'd2,
        HI_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   z_lo;
    logic [DATA_W-1:0]   z_hi;
    logic                wide_q;
    logic [DATA_W-1:0]   bus_q;
    logic                drive_q;
    logic                err_q;
    logic                consume;
    logic                capture;

    // The read in this cycle frees the stage; low wins when both requests are present.
    always_comb begin
        consume = 1'b0;
        case (state)
            FULL:    consume = zif.rd_lo && !wide_q;
            LO_DONE: consume = zif.rd_hi && !zif.rd_lo;
            HI_DONE: consume = zif.rd_lo;
            default: consume = 1'b0;
        endcase
    end

    assign zif.alu_ready = (state == EMPTY) || consume;
    assign capture       = zif.alu_valid && zif.alu_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= EMPTY;
            z_lo    <= '0;
            z_hi    <= '0;
            wide_q  <= 1'b0;
            bus_q   <= '0;
            drive_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            drive_q <= 1'b0;
            err_q   <= 1'b0;
            // Reads are evaluated against the old state and old halves, so a
            // same-cycle capture never affects what is driven this time.
            case (state)
                EMPTY: begin
                    if (zif.rd_lo || zif.rd_hi) begin
                        err_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (zif.rd_lo) begin
                        bus_q   <= z_lo;
                        drive_q <= 1'b1;
                        state   <= wide_q ? LO_DONE : EMPTY;
                    end else if (zif.rd_hi) begin
                        // Narrow result: z_hi is 0 and the result stays unconsumed.
                        bus_q   <= z_hi;
                        drive_q <= 1'b1;
                        if (wide_q) begin
                            state <= HI_DONE;
                        end
                    end
                end
                LO_DONE: begin
                    if (zif.rd_lo) begin
                        bus_q   <= z_lo;
                        drive_q <= 1'b1;
                    end else if (zif.rd_hi) begin
                        bus_q   <= z_hi;
                        drive_q <= 1'b1;
                        state   <= EMPTY;
                    end
                end
                HI_DONE: begin
                    if (zif.rd_lo) begin
                        bus_q   <= z_lo;
                        drive_q <= 1'b1;
                        state   <= EMPTY;
                    end else if (zif.rd_hi) begin
                        bus_q   <= z_hi;
                        drive_q <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (capture) begin
                z_lo   <= zif.alu_result[DATA_W-1:0];
                z_hi   <= zif.alu_wide ? zif.alu_result[2*DATA_W-1:DATA_W] : '0;
                wide_q <= zif.alu_wide;
                state  <= FULL;
            end
        end
    end

    assign zif.bus_out   = bus_q;
    assign zif.bus_drive = drive_q;
    assign zif.rd_err    = err_q;
    assign zif.busy      = (state != EMPTY);

`ifdef Z_RESULT_FLAGS_EN
    logic zero_q;
    logic neg_q;

    // Flags describe the last captured result and survive its consumption.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (capture) begin
            if (zif.alu_wide) begin
                zero_q <= (zif.alu_result == '0);
                neg_q  <= zif.alu_result[2*DATA_W-1];
            end else begin
                zero_q <= (zif.alu_result[DATA_W-1:0] == '0);
                neg_q  <= zif.alu_result[DATA_W-1];
            end
        end
    end

    assign zif.flag_zero = zero_q;
    assign zif.flag_neg  = neg_q;
`else
    assign zif.flag_zero = 1'b0;
    assign zif.flag_neg  = 1'b0;
`endif
endmodule
